// File: rtl/mult_pkg.sv
// Shared constants and FSM state type for the sequential wide multiplier
// and its 26x17 DSP multiplier stage.
package mult_pkg;

  localparam int LIMB_A_W = 26;
  localparam int LIMB_B_W = 17;
  localparam int PROD_W   = 43;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/wide_mult_seq_if.sv
// Operand/result bundle for wide_mult_seq: the requester drives start and the
// operands, the multiplier returns busy, done and the product register.
interface wide_mult_seq_if
  import mult_pkg::*;
#(
  parameter int NA = 4,
  parameter int NB = 6
) ();

  localparam int A_W = NA * LIMB_A_W;
  localparam int B_W = NB * LIMB_B_W;
  localparam int P_W = A_W + B_W;

  logic           start;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           busy;
  logic           done;
  logic [P_W-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/mult_26x17.sv
// Unsigned 26x17 multiplier with a registered product, matching a single DSP
// slice with its output register enabled.
module mult_26x17
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LIMB_A_W-1:0] x,
  input  logic [LIMB_B_W-1:0] y,
  output logic [PROD_W-1:0]   prod
);

  logic [PROD_W-1:0] prod_d;
  logic [PROD_W-1:0] prod_q;

  always_comb begin
    prod_d = {{(PROD_W-LIMB_A_W){1'b0}}, x} * {{(PROD_W-LIMB_B_W){1'b0}}, y};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/wide_mult_seq.sv
// Sequential (NA*26)x(NB*17) unsigned multiplier: one limb pair per cycle
// through a single mult_26x17, shifted partial products summed into p.
module wide_mult_seq
  import mult_pkg::*;
#(
  parameter int NA = 4,
  parameter int NB = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  wide_mult_seq_if.slave  bus
);

  localparam int A_W  = NA * LIMB_A_W;
  localparam int B_W  = NB * LIMB_B_W;
  localparam int P_W  = A_W + B_W;
  localparam int SH_W = $clog2(P_W);
  localparam int IW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW   = (NB > 1) ? $clog2(NB) : 1;

  state_e              state_q, state_d;
  logic                drain_q, drain_d;
  logic [IW-1:0]       i_q, i_d;
  logic [JW-1:0]       j_q, j_d;
  logic [A_W-1:0]      a_q, a_d;
  logic [B_W-1:0]      b_q, b_d;
  logic                s1_valid_q, s1_valid_d;
  logic [LIMB_A_W-1:0] s1_x_q, s1_x_d;
  logic [LIMB_B_W-1:0] s1_y_q, s1_y_d;
  logic [SH_W-1:0]     s1_shift_q, s1_shift_d;
  logic                s2_valid_q, s2_valid_d;
  logic [SH_W-1:0]     s2_shift_q, s2_shift_d;
  logic [P_W-1:0]      acc_q, acc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROD_W-1:0]   prod;

  mult_26x17 u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (s1_x_q),
    .y     (s1_y_q),
    .prod  (prod)
  );

  // Issue order is B limb outer, A limb inner; the accumulator clear on accept
  // wins over the add because the pipeline is always empty in IDLE.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    i_d        = i_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    s1_valid_d = 1'b0;
    s1_x_d     = a_q[int'(i_q)*LIMB_A_W +: LIMB_A_W];
    s1_y_d     = b_q[int'(j_q)*LIMB_B_W +: LIMB_B_W];
    s1_shift_d = SH_W'(int'(i_q)*LIMB_A_W + int'(j_q)*LIMB_B_W);
    s2_valid_d = s1_valid_q;
    s2_shift_d = s1_shift_q;
    acc_d      = acc_q;
    done_d     = 1'b0;

    if (s2_valid_q) begin
      acc_d = acc_q + (P_W'(prod) << s2_shift_q);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s1_valid_d = 1'b1;
        if (i_q == IW'(NA-1)) begin
          i_d = '0;
          if (j_q == JW'(NB-1)) begin
            j_d     = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drain_q    <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_shift_q <= '0;
      s2_valid_q <= 1'b0;
      s2_shift_q <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      i_q        <= i_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_shift_q <= s1_shift_d;
      s2_valid_q <= s2_valid_d;
      s2_shift_q <= s2_shift_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = acc_q;

endmodule

// File: tb/tb_wide_mult_seq.sv
// Directed self-checking bench for wide_mult_seq at the default 4x6 limb size
// (104-bit x 102-bit, latency 27 cycles).
module tb_wide_mult_seq;

  localparam int NA  = 4;
  localparam int NB  = 6;
  localparam int A_W = 104;
  localparam int B_W = 102;
  localparam int P_W = 206;
  localparam int LAT = 27;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  wide_mult_seq_if #(.NA(NA), .NB(NB)) bus ();

  wide_mult_seq #(.NA(NA), .NB(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Starts one operation (cycle 0 = accept cycle) and observes cycles 1..40.
  task automatic run_op(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                        output int done_cyc, output int done_cnt,
                        output logic [P_W-1:0] p_done, output int overlap);
    done_cyc = -1;
    done_cnt = 0;
    p_done   = '0;
    overlap  = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          p_done   = bus.p;
        end
        if (bus.busy !== 1'b0) overlap++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.p !== '0) begin
      errors++; $display("[TB] FAIL reset_p got=%h exp=0", bus.p);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_unit();
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.a     = A_W'(1);
    bus.b     = B_W'(1);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== (cyc <= LAT - 1)) begin
        errors++;
        $display("[TB] FAIL unit_busy cyc=%0d got=%b exp=%b", cyc, bus.busy, (cyc <= LAT - 1));
      end
      checks++;
      if (bus.done !== (cyc == LAT)) begin
        errors++;
        $display("[TB] FAIL unit_done cyc=%0d got=%b exp=%b", cyc, bus.done, (cyc == LAT));
      end
      if (cyc == 1 || cyc == LAT) begin
        checks++;
        if (bus.p !== ((cyc == LAT) ? P_W'(1) : P_W'(0))) begin
          errors++;
          $display("[TB] FAIL unit_p cyc=%0d got=%h exp=%0d", cyc, bus.p, (cyc == LAT));
        end
      end
    end
  endtask

  task automatic test_products();
    logic [A_W-1:0] av [4];
    logic [B_W-1:0] bv [4];
    logic [P_W-1:0] ev [4];
    int             dc, dn, ov;
    logic [P_W-1:0] pd;
    av[0] = A_W'(1) << 26;                 bv[0] = B_W'(1) << 17;
    ev[0] = P_W'(1) << 43;
    av[1] = '1;                            bv[1] = '1;
    ev[1] = P_W'(0) - (P_W'(1) << 104) - (P_W'(1) << 102) + P_W'(1);
    av[2] = (A_W'(1) << 78) + A_W'(5);     bv[2] = (B_W'(1) << 85) + B_W'(3);
    ev[2] = (P_W'(1) << 163) + (P_W'(3) << 78) + (P_W'(5) << 85) + P_W'(15);
    av[3] = A_W'(123456);                  bv[3] = B_W'(1000);
    ev[3] = P_W'(123456000);
    for (int k = 0; k < 4; k++) begin
      run_op(av[k], bv[k], dc, dn, pd, ov);
      checks++;
      if (dc != LAT) begin
        errors++; $display("[TB] FAIL prod%0d_latency got=%0d exp=%0d", k, dc, LAT);
      end
      checks++;
      if (pd !== ev[k]) begin
        errors++; $display("[TB] FAIL prod%0d_value got=%h exp=%h", k, pd, ev[k]);
      end
      checks++;
      if (dn != 1 || ov != 0) begin
        errors++; $display("[TB] FAIL prod%0d_done_pulses got=%0d/%0d exp=1/0", k, dn, ov);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int             dc, dn;
    logic [P_W-1:0] pd;
    dc = -1; dn = 0; pd = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = A_W'(7); bus.b = B_W'(9);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 5) begin
        bus.start = 1'b1; bus.a = A_W'(100); bus.b = B_W'(100);
      end
      if (cyc == 6) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dn++;
        if (dc < 0) begin dc = cyc; pd = bus.p; end
      end
      if (cyc == 35) begin
        checks++;
        if (bus.p !== P_W'(63)) begin
          errors++; $display("[TB] FAIL busy_start_hold got=%h exp=63", bus.p);
        end
      end
    end
    checks++;
    if (dc != LAT || dn != 1) begin
      errors++; $display("[TB] FAIL busy_start_done got=cyc%0d/cnt%0d exp=cyc%0d/cnt1", dc, dn, LAT);
    end
    checks++;
    if (pd !== P_W'(63)) begin
      errors++; $display("[TB] FAIL busy_start_value got=%h exp=63", pd);
    end
  endtask

  task automatic test_back_to_back();
    int dn;
    dn = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = A_W'(3); bus.b = B_W'(5);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 || cyc == LAT + 1) bus.start = 1'b0;
      if (cyc == LAT) begin
        bus.start = 1'b1; bus.a = A_W'(11); bus.b = B_W'(13);
      end
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      if (cyc == LAT) begin
        checks++;
        if (bus.done !== 1'b1 || bus.p !== P_W'(15)) begin
          errors++; $display("[TB] FAIL b2b_first got=done%b/p%h exp=done1/p15", bus.done, bus.p);
        end
      end
      if (cyc == LAT + 1) begin
        checks++;
        if (bus.p !== '0 || bus.busy !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_clear got=p%h/busy%b exp=p0/busy1", bus.p, bus.busy);
        end
      end
      if (cyc == 2 * LAT) begin
        checks++;
        if (bus.done !== 1'b1 || bus.p !== P_W'(143)) begin
          errors++; $display("[TB] FAIL b2b_second got=done%b/p%h exp=done1/p143", bus.done, bus.p);
        end
      end
    end
    checks++;
    if (dn != 2) begin
      errors++; $display("[TB] FAIL b2b_done_count got=%0d exp=2", dn);
    end
  endtask

  task automatic test_reset_mid_op();
    int             dn, dc, ov;
    logic [P_W-1:0] pd;
    dn = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = A_W'(1) << 26; bus.b = B_W'(1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == 10) rst_n = 1'b0;
      if (cyc == 11) rst_n = 1'b1;
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      if (cyc == 11) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.p !== '0 || bus.done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL midreset_state got=busy%b/done%b/p%h exp=busy0/done0/p0",
                   bus.busy, bus.done, bus.p);
        end
      end
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("[TB] FAIL midreset_no_done got=%0d exp=0", dn);
    end
    run_op(A_W'(6), B_W'(7), dc, dn, pd, ov);
    checks++;
    if (dc != LAT || pd !== P_W'(42) || dn != 1) begin
      errors++; $display("[TB] FAIL midreset_fresh got=cyc%0d/p%h/cnt%0d exp=cyc%0d/p42/cnt1",
                         dc, pd, dn, LAT);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unit();
    test_products();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
